segre_mem_issue_queue: RTL

//  Parametrised successor of the single-latch EX->TL front end of the memory pipeline. Computes the

---
 rtl/segre_pkg.sv | 40 ++++
 rtl/segre_mem_agu.sv | 32 +++
 rtl/segre_mem_issue_queue.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/segre_pkg.sv
// Shared types for the segre memory pipeline front end.
package segre_pkg;

    localparam int unsigned SEGRE_WORD_W = 32;
    localparam int unsigned SEGRE_ADDR_W = 32;
    localparam int unsigned SEGRE_REG_W  = 5;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    // One buffered memory operation as seen by the TL stage.
    typedef struct packed {
        logic [SEGRE_ADDR_W-1:0] addr;
        logic                    rf_we;
        logic [SEGRE_REG_W-1:0]  rf_waddr;
        logic [SEGRE_WORD_W-1:0] st_data;
        logic                    rd;
        logic                    wr;
        logic                    sign_ext;
        memop_data_type_e        mtype;
        logic                    misalign;
    } mem_issue_entry_t;

    // Idle entry value: everything zero except the access size, which idles at WORD.
    localparam mem_issue_entry_t MEM_ISSUE_ENTRY_RST = '{
        addr:     '0,
        rf_we:    1'b0,
        rf_waddr: '0,
        st_data:  '0,
        rd:       1'b0,
        wr:       1'b0,
        sign_ext: 1'b0,
        mtype:    WORD,
        misalign: 1'b0
    };

endpackage

// File: rtl/segre_mem_agu.sv
// Address generation: base + offset (carry dropped) and natural-alignment check.
module segre_mem_agu
    import segre_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter bit          ALIGN_CHK = 1'b1
) (
    input  logic [WORD_W-1:0] src_a_i,
    input  logic [WORD_W-1:0] src_b_i,
    input  memop_data_type_e  type_i,
    output logic [ADDR_W-1:0] addr_c,
    output logic              misalign_c
);

    logic [WORD_W-1:0] sum;

    // Effective address and misalignment flag.
    always_comb begin
        sum        = src_a_i + src_b_i;
        addr_c     = ADDR_W'(sum);
        misalign_c = 1'b0;
        if (ALIGN_CHK) begin
            case (type_i)
                HALF:    misalign_c = addr_c[0];
                WORD:    misalign_c = (addr_c[1:0] != 2'b00);
                default: misalign_c = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/segre_mem_issue_queue.sv
// EX->TL memory issue queue: AGU plus a DEPTH-entry valid/ready FIFO with flush.
module segre_mem_issue_queue
    import segre_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned DEPTH     = 4,
    parameter bit          ALIGN_CHK = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rsn_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [WORD_W-1:0]      alu_src_a_i,
    input  logic [WORD_W-1:0]      alu_src_b_i,
    input  logic                   rf_we_i,
    input  logic [REG_W-1:0]       rf_waddr_i,
    input  logic [WORD_W-1:0]      rf_st_data_i,
    input  logic                   memop_rd_i,
    input  logic                   memop_wr_i,
    input  logic                   memop_sign_ext_i,
    input  memop_data_type_e       memop_type_i,
    input  logic                   flush_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [ADDR_W-1:0]      addr_o,
    output logic                   rf_we_o,
    output logic [REG_W-1:0]       rf_waddr_o,
    output logic [WORD_W-1:0]      rf_st_data_o,
    output logic                   memop_rd_o,
    output logic                   memop_wr_o,
    output logic                   memop_sign_ext_o,
    output memop_data_type_e       memop_type_o,
    output logic                   misalign_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    mem_issue_entry_t   mem_q [DEPTH];
    mem_issue_entry_t   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [ADDR_W-1:0]  agu_addr;
    logic               agu_misalign;
    logic               push_c;
    logic               pop_c;
    mem_issue_entry_t   new_entry;
    mem_issue_entry_t   head;

    segre_mem_agu #(
        .WORD_W    (WORD_W),
        .ADDR_W    (ADDR_W),
        .ALIGN_CHK (ALIGN_CHK)
    ) u_agu (
        .src_a_i    (alu_src_a_i),
        .src_b_i    (alu_src_b_i),
        .type_i     (memop_type_i),
        .addr_c     (agu_addr),
        .misalign_c (agu_misalign)
    );

    // Handshakes; flush overrides both push and pop.
    always_comb begin
        ready_o = (count_q != CNT_W'(DEPTH));
        valid_o = (count_q != CNT_W'(0));
        push_c  = valid_i && ready_o && (memop_rd_i || memop_wr_i) && !flush_i;
        pop_c   = valid_o && ready_i && !flush_i;
    end

    // Build the entry to store; a misaligned access is killed but still travels.
    always_comb begin
        new_entry          = MEM_ISSUE_ENTRY_RST;
        new_entry.addr     = SEGRE_ADDR_W'(agu_addr);
        new_entry.rf_we    = rf_we_i && !agu_misalign;
        new_entry.rf_waddr = SEGRE_REG_W'(rf_waddr_i);
        new_entry.st_data  = SEGRE_WORD_W'(rf_st_data_i);
        new_entry.rd       = memop_rd_i && !agu_misalign;
        new_entry.wr       = memop_wr_i && !agu_misalign;
        new_entry.sign_ext = memop_sign_ext_i;
        new_entry.mtype    = memop_type_i;
        new_entry.misalign = agu_misalign;
    end

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_c) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= MEM_ISSUE_ENTRY_RST;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Head entry fields toward TL.
    always_comb begin
        head             = mem_q[rd_ptr_q];
        addr_o           = ADDR_W'(head.addr);
        rf_we_o          = head.rf_we;
        rf_waddr_o       = REG_W'(head.rf_waddr);
        rf_st_data_o     = WORD_W'(head.st_data);
        memop_rd_o       = head.rd;
        memop_wr_o       = head.wr;
        memop_sign_ext_o = head.sign_ext;
        memop_type_o     = head.mtype;
        misalign_o       = head.misalign;
        count_o          = count_q;
    end

endmodule
